// File: rtl/ip_route_buf.sv
// Input-port flit buffer with XY route decode. The decoded direction is captured
// from the head flit and held until that packet's eof flit is handed off.
//
// state | meaning
// IDLE  | no packet open; a non-empty FIFO head is decoded as a head flit
// SEND  | packet open; FIFO head presented with the held direction until eof
module ip_route_buf #(
   parameter int DW    = 8,
   parameter int AW    = 2,
   parameter int DEPTH = 4,
   parameter int PX    = 0,
   parameter int PY    = 0,
   parameter int SN    = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_vld,
   input  logic [DW-1:0]            in_data,
   input  logic                     in_eof,
   output logic                     in_rdy,
   output logic                     out_vld,
   output logic [DW-1:0]            out_data,
   output logic                     out_eof,
   output logic [SN-1:0]            out_dec,
   input  logic                     out_rdy,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [AW-1:0] LX = AW'(PX);
   localparam logic [AW-1:0] LY = AW'(PY);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t          r_state;
   logic [DW:0]     r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW:0]     r_fill;
   logic [SN-1:0]   r_dec;

   logic            w_wr;
   logic            w_rd;
   logic [DW:0]     w_head;

   // Direction bit order: [0]N [1]E [2]S [3]W [4]L; X is resolved before Y.
   function automatic logic [SN-1:0] xy_dec(input logic [2*AW-1:0] coord);
      logic [AW-1:0] dx;
      logic [AW-1:0] dy;
      dx = coord[AW-1:0];
      dy = coord[2*AW-1:AW];
      xy_dec = '0;
      if (dx > LX)      xy_dec[1] = 1'b1;
      else if (dx < LX) xy_dec[3] = 1'b1;
      else if (dy > LY) xy_dec[0] = 1'b1;
      else if (dy < LY) xy_dec[2] = 1'b1;
      else              xy_dec[4] = 1'b1;
   endfunction

   assign w_head   = r_mem[r_rd_ptr];
   assign in_rdy   = (r_fill != FULL);
   assign out_vld  = (r_state == SEND) && (r_fill != '0);
   assign out_data = w_head[DW-1:0];
   assign out_eof  = w_head[DW];
   assign out_dec  = r_dec;
   assign fill     = r_fill;
   assign w_wr     = in_vld & in_rdy;
   assign w_rd     = out_vld & out_rdy;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {in_eof, in_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_dec   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_fill != '0) begin
                  r_dec   <= xy_dec(w_head[2*AW-1:0]);
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (w_rd && w_head[DW]) begin
                  r_dec   <= '0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_dec   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
